// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
//   Multi-cycle shift-add multiplier that sits beside the ALU and serves the
//   multiply-class opcodes MULT (4'b0110) and SQU (4'b0101). It stalls the
//   pipeline while iterating, then holds a registered product for write-back.
//   Every other opcode is ignored.
//
// Parameters
//   WIDTH       operand / result width in bits
//   EARLY_EXIT  1: stop once the remaining multiplier bits are all zero
//               0: always run WIDTH iterations
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   start         in   request, sampled only in IDLE
//   ALUOperation  in   [3:0] opcode from ALUControl
//   A             in   [WIDTH-1:0] multiplicand (also multiplier for SQU)
//   B             in   [WIDTH-1:0] multiplier for MULT, ignored for SQU
//   stall         out  combinational pipeline hold
//   busy          out  registered, high while iterating
//   done          out  registered one-cycle result-valid pulse
//   Result        out  [WIDTH-1:0] low half of the product
//   Overflow      out  OR of the upper half of the product
// -----------------------------------------------------------------------------
module mult_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] op_mult = 4'b0110;
  localparam logic [3:0] op_squ  = 4'b0101;

  localparam logic [1:0] st_idle = 2'b00;
  localparam logic [1:0] st_run  = 2'b01;
  localparam logic [1:0] st_done = 2'b10;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  logic               accept;
  logic               is_squ;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_next;
  logic               last_iter;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    is_squ      = 1'b0;
    accept      = 1'b0;
    acc_next    = acc;
    mplier_next = mplier >> 1;
    last_iter   = 1'b0;

    is_squ = (ALUOperation == op_squ);
    accept = start && ((ALUOperation == op_mult) || is_squ);

    if (mplier[0]) begin
      acc_next = acc + mcand;
    end

    // Exit test looks at the multiplier as it will be after this shift, so
    // the final add happens on the exit cycle itself.
    last_iter = (count == CW'(WIDTH - 1)) ||
                (EARLY_EXIT && (mplier_next == '0));
  end

  assign stall = ((state == st_idle) && accept) || (state == st_run);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= st_idle;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
      Overflow <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
    end else begin
      case (state)
        st_idle: begin
          done <= 1'b0;
          if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= is_squ ? A : B;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= st_run;
          end
        end

        st_run: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          count  <= count + 1'b1;
          if (last_iter) begin
            Result   <= acc_next[WIDTH-1:0];
            Overflow <= |acc_next[2*WIDTH-1:WIDTH];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= st_done;
          end
        end

        st_done: begin
          // start is deliberately not looked at here; a held request is
          // picked up on the following IDLE cycle.
          done  <= 1'b0;
          state <= st_idle;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
//   Directed bench for mult_sequencer. Two instances share the operand bus:
//   u_full (EARLY_EXIT=0) and u_early (EARLY_EXIT=1), each with its own start.
//   A vector table covers products, overflow and latency; hand-written
//   sequences cover non-multiply opcodes, reset mid-run and held start.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;

  localparam int W = 32;
  localparam logic [3:0] OP_MULT = 4'b0110;
  localparam logic [3:0] OP_SQU  = 4'b0101;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start0 = 1'b0;
  logic         start1 = 1'b0;
  logic [3:0]   op = 4'b0000;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;

  logic         stall0, busy0, done0, ovf0;
  logic [W-1:0] res0;
  logic         stall1, busy1, done1, ovf1;
  logic [W-1:0] res1;

  // Selects which instance the shared helpers observe.
  logic         sel = 1'b0;
  logic         stall_s, busy_s, done_s, ovf_s;
  logic [W-1:0] res_s;

  assign stall_s = sel ? stall1 : stall0;
  assign busy_s  = sel ? busy1  : busy0;
  assign done_s  = sel ? done1  : done0;
  assign ovf_s   = sel ? ovf1   : ovf0;
  assign res_s   = sel ? res1   : res0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
    .clk          (clk),
    .reset        (reset),
    .start        (start0),
    .ALUOperation (op),
    .A            (A),
    .B            (B),
    .stall        (stall0),
    .busy         (busy0),
    .done         (done0),
    .Result       (res0),
    .Overflow     (ovf0)
  );

  mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_early (
    .clk          (clk),
    .reset        (reset),
    .start        (start1),
    .ALUOperation (op),
    .A            (A),
    .B            (B),
    .stall        (stall1),
    .busy         (busy1),
    .done         (done1),
    .Result       (res1),
    .Overflow     (ovf1)
  );

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    bit           ee;      // 1: u_early, 0: u_full
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    bit           exp_o;
    int           exp_n;   // number of RUN cycles
    string        name;
  } vec_t;

  // Start in cycle 0, scramble operands once accepted, then expect
  // done in cycle exp_n+1 with stall/busy high throughout RUN.
  task automatic run_op(input vec_t v);
    int cyc;
    bit run_ok;
    sel = v.ee;
    @(posedge clk); #1;
    op = v.op; A = v.a; B = v.b;
    if (v.ee) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    run_ok = (stall_s === 1'b1) && (busy_s === 1'b0);
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    A = $urandom; B = $urandom;
    cyc = 1;
    while (cyc <= 100) begin
      @(negedge clk);
      if (done_s === 1'b1) break;
      if (!((stall_s === 1'b1) && (busy_s === 1'b1))) run_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({v.name, "_done_cycle"}, 64'(cyc), 64'(v.exp_n + 1));
    check({v.name, "_result"}, 64'(res_s), 64'(v.exp_r));
    check({v.name, "_overflow"}, 64'(ovf_s), 64'(v.exp_o));
    check({v.name, "_done_stall_busy"}, {62'd0, stall_s, busy_s}, 64'd0);
    check({v.name, "_run_stall"}, 64'(run_ok), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check({v.name, "_done_pulse"}, 64'(done_s), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [8:0] done_v, stall_v, busy_v;
    logic [W-1:0] r_c2, r_c7;
    bit quiet;

    vecs[0] = '{1'b0, OP_MULT, 32'd7, 32'd6, 32'd42, 1'b0, 32, "mult_7x6_full"};
    vecs[1] = '{1'b1, OP_SQU, 32'd12, 32'd999, 32'd144, 1'b0, 4, "squ_12_early"};
    vecs[2] = '{1'b0, OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 32,
                "mult_2p16sq_full"};
    vecs[3] = '{1'b0, OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 32,
                "mult_max_x2_full"};
    vecs[4] = '{1'b1, OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 2,
                "mult_max_x2_early"};
    vecs[5] = '{1'b1, OP_MULT, 32'd5, 32'd0, 32'd0, 1'b0, 1, "mult_by0_early"};
    vecs[6] = '{1'b1, OP_MULT, 32'h1234_5678, 32'd9, 32'hA3D7_0A38, 1'b0, 4,
                "mult_x9_early"};
    vecs[7] = '{1'b1, OP_SQU, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 32,
                "squ_max_early"};
    vecs[8] = '{1'b1, OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 32,
                "mult_msb_early"};
    vecs[9] = '{1'b0, OP_SQU, 32'd3, 32'd77, 32'd9, 1'b0, 32, "squ_3_full"};

    // Reset state.
    #12;
    check("reset_full", {59'd0, stall0, busy0, done0, ovf0, |res0}, 64'd0);
    check("reset_early", {59'd0, stall1, busy1, done1, ovf1, |res1}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Non-multiply opcodes are ignored: u_full keeps Result=9 from squ_3_full.
    sel = 1'b0;
    quiet = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b1; op = 4'b0011; A = 32'd3; B = 32'd4;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) op = 4'b0000;
      @(negedge clk);
      if (stall0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    check("nonmult_quiet", 64'(quiet), 64'd1);
    check("nonmult_result_held", 64'(res0), 64'd9);

    // Reset asserted in cycle 2 of a MULT aborts it.
    op = OP_MULT; A = 32'd3; B = 32'd5; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_midrun_outs", {61'd0, stall0, busy0, ovf0}, 64'd0);
    check("rst_midrun_result", 64'(res0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) quiet = 1'b0;
    end
    check("rst_midrun_no_done", 64'(quiet), 64'd1);
    run_op('{1'b0, OP_MULT, 32'd3, 32'd5, 32'd15, 1'b0, 32, "mult_3x5_after_rst"});

    // Held start on u_early: 5*0 (done cycle 2), then 6*7 accepted in
    // cycle 3 (3 RUN cycles, done cycle 7); operands toggle mid-RUN.
    sel = 1'b1;
    r_c2 = '1; r_c7 = '0;
    @(posedge clk); #1;
    op = OP_MULT; A = 32'd5; B = 32'd0; start1 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) begin A = 32'd6; B = 32'd7; end
      if (c == 4) begin A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; end
      if (c == 5) start1 = 1'b0;
      @(negedge clk);
      done_v[c]  = done1;
      stall_v[c] = stall1;
      busy_v[c]  = busy1;
      if (c == 2) r_c2 = res1;
      if (c == 7) r_c7 = res1;
      @(posedge clk); #1;
    end
    check("held_done_pattern", 64'(done_v), 64'h084);
    check("held_stall_pattern", 64'(stall_v), 64'h07B);
    check("held_busy_pattern", 64'(busy_v), 64'h072);
    check("held_first_result", 64'(r_c2), 64'd0);
    check("held_second_result", 64'(r_c7), 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop against a wedged run.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
